// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 master: FSM encodings, default bus widths
// and elaboration-time width helpers.
package apb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Slave-index width; a single slave still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Per-slave lane selection (prdata/pready/pslverr) and one-hot psel decode.
module apb_slv_mux
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [IDX_W-1:0]                 sel_idx,
  input  logic [IDX_W-1:0]                 dec_idx,
  input  logic                             dec_en,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  output logic [DATA_WIDTH-1:0]            prdata_c,
  output logic                             pready_c,
  output logic                             pslverr_c,
  output logic [NUM_SLAVES-1:0]            psel_c
);

  // Out-of-range indices match no lane and read back as zero.
  always_comb begin
    prdata_c  = '0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    psel_c    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        prdata_c  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
        pready_c  = pready[i];
        pslverr_c = pslverr[i];
      end
      if (dec_en && (dec_idx == IDX_W'(i))) psel_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb3_master_ctrl.sv
// APB3 master: valid/ready command port to an APB bus with address-decoded
// slave selects, wait states, slave errors and a wait-state timeout.
module apb3_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SLV_IDX_LSB    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned IDX_W    = idx_width(NUM_SLAVES);
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? idx_width(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  apb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic [IDX_W-1:0]      cmd_idx;
  logic                  idx_ok;
  logic [DATA_WIDTH-1:0] prdata_c;
  logic                  pready_c;
  logic                  pslverr_c;
  logic [NUM_SLAVES-1:0] psel_c;

  assign cmd_idx   = cmd_addr[SLV_IDX_LSB +: IDX_W];
  assign idx_ok    = {1'b0, cmd_idx} < (IDX_W + 1)'(NUM_SLAVES);
  assign cmd_ready = (state_q == ST_IDLE) && !reset;

  apb_slv_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .sel_idx   (idx_q),
    .dec_idx   (cmd_idx),
    .dec_en    (idx_ok),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata_c  (prdata_c),
    .pready_c  (pready_c),
    .pslverr_c (pslverr_c),
    .psel_c    (psel_c)
  );

  // Next-state and registered-output logic; responses default to a single-cycle pulse.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          idx_d    = cmd_idx;
          if (idx_ok) begin
            state_d = ST_SETUP;
            psel_d  = psel_c;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // pready is checked first so a ready on the last allowed cycle still completes.
        if (pready_c) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_c;
          rsp_rdata_d = pwrite_q ? '0 : prdata_c;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
          state_d       = ST_IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_master_ctrl.sv
// Directed bench for apb3_master_ctrl: a 4-slave and a 3-slave instance
// driven on the falling edge and checked against hand-computed values.
module tb_apb3_master_ctrl;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  logic        cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;

  logic         rst4, v4, r4, rv4, re4, rt4, pe4, pw4;
  logic [31:0]  rd4, pa4, pwd4;
  logic [3:0]   ps4, prdy4, perr4;
  logic [127:0] prd4;

  logic         rst3, v3, r3, rv3, re3, rt3, pe3, pw3;
  logic [31:0]  rd3, pa3, pwd3;
  logic [2:0]   ps3, prdy3, perr3;
  logic [95:0]  prd3;

  apb3_master_ctrl #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) u_dut4 (
    .pclk(pclk), .reset(rst4), .cmd_valid(v4), .cmd_ready(r4),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(re4), .rsp_timeout(rt4),
    .psel(ps4), .penable(pe4), .pwrite(pw4), .paddr(pa4), .pwdata(pwd4),
    .prdata(prd4), .pready(prdy4), .pslverr(perr4)
  );

  apb3_master_ctrl #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) u_dut3 (
    .pclk(pclk), .reset(rst3), .cmd_valid(v3), .cmd_ready(r3),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3), .rsp_timeout(rt3),
    .psel(ps3), .penable(pe3), .pwrite(pw3), .paddr(pa3), .pwdata(pwd3),
    .prdata(prd3), .pready(prdy3), .pslverr(perr3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1; rst3 = 1'b1; v4 = 1'b0; v3 = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdy4 = '0; perr4 = '0; prd4 = '0;
    prdy3 = '0; perr3 = '0; prd3 = '0;
    repeat (2) @(negedge pclk);

    // Reset state
    chk("rst_psel", 32'(ps4), 32'h0);
    chk("rst_penable", 32'(pe4), 32'h0);
    chk("rst_rsp_valid", 32'(rv4), 32'h0);
    chk("rst_paddr", pa4, 32'h0);
    chk("rst_pwdata", pwd4, 32'h0);
    chk("rst_cmd_ready_in_reset", 32'(r4), 32'h0);
    rst4 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_cmd_ready_after", 32'(r4), 32'h1);

    // Test 1: write to slave 2, zero wait states
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 32'h0000_2010; cmd_wdata = 32'hDEAD_BEEF;
    v4 = 1'b1; prdy4 = 4'b0100;
    @(negedge pclk); v4 = 1'b0;
    chk("t1_setup_psel", 32'(ps4), 32'h4);
    chk("t1_setup_penable", 32'(pe4), 32'h0);
    chk("t1_pwrite", 32'(pw4), 32'h1);
    chk("t1_paddr", pa4, 32'h0000_2010);
    chk("t1_pwdata", pwd4, 32'hDEAD_BEEF);
    chk("t1_busy_ready", 32'(r4), 32'h0);
    @(negedge pclk);
    chk("t1_access_psel", 32'(ps4), 32'h4);
    chk("t1_access_penable", 32'(pe4), 32'h1);
    chk("t1_access_rsp_valid", 32'(rv4), 32'h0);
    @(negedge pclk);
    chk("t1_done_psel", 32'(ps4), 32'h0);
    chk("t1_done_penable", 32'(pe4), 32'h0);
    chk("t1_rsp_valid", 32'(rv4), 32'h1);
    chk("t1_rsp_err", 32'(re4), 32'h0);
    chk("t1_rsp_rdata", rd4, 32'h0);
    chk("t1_cmd_ready", 32'(r4), 32'h1);
    @(negedge pclk);
    chk("t1_rsp_pulse", 32'(rv4), 32'h0);
    chk("t1_paddr_hold", pa4, 32'h0000_2010);

    // Test 2: read slave 1 with 3 wait states; other lanes ready/erroring
    prd4[63:32] = 32'h1234_5678; prd4[95:64] = 32'hAAAA_5555;
    prdy4 = 4'b0100; perr4 = 4'b1000;
    cmd_write = 1'b0; cmd_addr = 32'h0000_1004; v4 = 1'b1;
    @(negedge pclk); v4 = 1'b0;
    chk("t2_setup_psel", 32'(ps4), 32'h2);
    chk("t2_setup_penable", 32'(pe4), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("t2_access_psel", 32'(ps4), 32'h2);
      chk("t2_access_penable", 32'(pe4), 32'h1);
      chk("t2_access_paddr", pa4, 32'h0000_1004);
      chk("t2_access_ready", 32'(r4), 32'h0);
      chk("t2_access_rsp_valid", 32'(rv4), 32'h0);
      if (i == 3) prdy4 = 4'b0110;
    end
    @(negedge pclk);
    chk("t2_rsp_valid", 32'(rv4), 32'h1);
    chk("t2_rsp_rdata", rd4, 32'h1234_5678);
    chk("t2_rsp_err", 32'(re4), 32'h0);
    chk("t2_done_psel", 32'(ps4), 32'h0);
    chk("t2_cmd_ready", 32'(r4), 32'h1);

    // Test 3: read slave 0 with pslverr; rdata still passed through
    prd4[31:0] = 32'hCAFE_0001; prdy4 = 4'b0001; perr4 = 4'b0001;
    cmd_addr = 32'h0000_0008; v4 = 1'b1;
    @(negedge pclk); v4 = 1'b0;
    chk("t3_setup_psel", 32'(ps4), 32'h1);
    @(negedge pclk);
    chk("t3_access_penable", 32'(pe4), 32'h1);
    @(negedge pclk);
    chk("t3_rsp_valid", 32'(rv4), 32'h1);
    chk("t3_rsp_err", 32'(re4), 32'h1);
    chk("t3_rsp_timeout", 32'(rt4), 32'h0);
    chk("t3_rsp_rdata", rd4, 32'hCAFE_0001);
    perr4 = 4'b0000;

    // Test 4a: slave 3 never ready -> timeout after 16 ACCESS cycles
    prd4[127:96] = 32'hBBBB_0003; prdy4 = 4'b0111;
    @(negedge pclk);
    cmd_addr = 32'h0000_3000; v4 = 1'b1;
    @(negedge pclk); v4 = 1'b0;
    chk("t4a_setup_psel", 32'(ps4), 32'h8);
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      chk("t4a_access_psel", 32'(ps4), 32'h8);
      chk("t4a_access_penable", 32'(pe4), 32'h1);
      chk("t4a_access_rsp_valid", 32'(rv4), 32'h0);
    end
    @(negedge pclk);
    chk("t4a_psel_dropped", 32'(ps4), 32'h0);
    chk("t4a_penable_dropped", 32'(pe4), 32'h0);
    chk("t4a_rsp_valid", 32'(rv4), 32'h1);
    chk("t4a_rsp_err", 32'(re4), 32'h1);
    chk("t4a_rsp_timeout", 32'(rt4), 32'h1);
    chk("t4a_rsp_rdata", rd4, 32'h0);

    // Test 4b: pready rises on the 16th ACCESS cycle -> normal completion
    cmd_addr = 32'h0000_3000; v4 = 1'b1;
    @(negedge pclk); v4 = 1'b0;
    chk("t4a_rsp_pulse", 32'(rv4), 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      chk("t4b_access_psel", 32'(ps4), 32'h8);
      if (i == 15) prdy4 = 4'b1111;
    end
    @(negedge pclk);
    chk("t4b_rsp_valid", 32'(rv4), 32'h1);
    chk("t4b_rsp_err", 32'(re4), 32'h0);
    chk("t4b_rsp_timeout", 32'(rt4), 32'h0);
    chk("t4b_rsp_rdata", rd4, 32'hBBBB_0003);

    // Test 5: 3-slave instance, decode error on index 3
    cmd_addr = 32'h0000_3000; v3 = 1'b1; prd3[31:0] = 32'h5555_0000;
    @(negedge pclk); v3 = 1'b0;
    chk("t5_dec_psel", 32'(ps3), 32'h0);
    chk("t5_dec_rsp_valid", 32'(rv3), 32'h1);
    chk("t5_dec_rsp_err", 32'(re3), 32'h1);
    chk("t5_dec_rsp_timeout", 32'(rt3), 32'h0);
    chk("t5_dec_rsp_rdata", rd3, 32'h0);
    chk("t5_dec_cmd_ready", 32'(r3), 32'h1);
    @(negedge pclk);
    chk("t5_dec_rsp_pulse", 32'(rv3), 32'h0);
    chk("t5_dec_psel_idle", 32'(ps3), 32'h0);

    // Test 5b: reset during ACCESS aborts with no response
    cmd_addr = 32'h0000_1000; prdy3 = 3'b000; v3 = 1'b1;
    @(negedge pclk); v3 = 1'b0;
    chk("t5_setup_psel", 32'(ps3), 32'h2);
    @(negedge pclk);
    chk("t5_access_penable", 32'(pe3), 32'h1);
    rst3 = 1'b1;
    @(negedge pclk);
    chk("t5_rst_psel", 32'(ps3), 32'h0);
    chk("t5_rst_penable", 32'(pe3), 32'h0);
    chk("t5_rst_rsp_valid", 32'(rv3), 32'h0);
    chk("t5_rst_cmd_ready", 32'(r3), 32'h0);
    rst3 = 1'b0;
    #1;
    chk("t5_post_rst_cmd_ready", 32'(r3), 32'h1);
    @(negedge pclk);
    chk("t5_post_rst_rsp_valid", 32'(rv3), 32'h0);
    chk("t5_post_rst_psel", 32'(ps3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
